// File: rtl/exc_pkg.sv
// exc_pkg -- shared definitions for the exception commit unit.
//   * Exception codes as written into CP0 Cause.ExcCode (zero-extended to 32b).
//   * CP0 register addresses that the WB-stage forwarding path watches.
//   * Bit indices of the MEM-stage exception flag vector.
//   * Priority-encoder result struct and redirect FSM state encoding.
// Optional feature macro EXC_TRAP_EN is consumed by exc_prio, not here.
package exc_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_TR   = 32'hd;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // mem_exc flag positions
  localparam int EF_ADEL_IF = 0;
  localparam int EF_RI      = 1;
  localparam int EF_OV      = 2;
  localparam int EF_TR      = 3;
  localparam int EF_SYS     = 4;
  localparam int EF_BP      = 5;
  localparam int EF_ADEL_LD = 6;
  localparam int EF_ADES    = 7;

  typedef enum logic [1:0] {
    BAD_NONE = 2'd0,
    BAD_PC   = 2'd1,
    BAD_DATA = 2'd2
  } bad_sel_e;

  typedef struct packed {
    logic [31:0] code;
    bad_sel_e    bad_sel;
  } prio_res_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_e;

  // Only the two software-interrupt bits of Cause are writable by mtc0;
  // everything else keeps the live hardware value.
  function automatic logic [31:0] cause_merge(input logic [31:0] cause,
                                              input logic [31:0] wdata);
    logic [31:0] r;
    r      = cause;
    r[9:8] = wdata[9:8];
    return r;
  endfunction

endpackage

// File: rtl/exc_prio.sv
// exc_prio -- combinational exception priority encoder.
// Ports:
//   valid_i  MEM stage holds a real instruction (bubbles never raise anything)
//   int_i    interrupt condition, already qualified by Status/Cause
//   exc_i    MEM-stage exception flags (bit layout in exc_pkg EF_*)
//   eret_i   MEM instruction is eret
//   res_o    winning exception code (0 = none) and bad-address source
// Macro EXC_TRAP_EN: when defined, the trap flag reports code 0xd; when not,
// trap is folded into reserved-instruction (0xa) at the same priority slot.
import exc_pkg::*;

module exc_prio (
  input  logic       valid_i,
  input  logic       int_i,
  input  logic [7:0] exc_i,
  input  logic       eret_i,
  output prio_res_t  res_o
);

`ifdef EXC_TRAP_EN
  localparam logic [31:0] TRAP_CODE = EXC_TR;
`else
  localparam logic [31:0] TRAP_CODE = EXC_RI;
`endif

  always_comb begin
    res_o.code    = EXC_NONE;
    res_o.bad_sel = BAD_NONE;
    if (valid_i) begin
      if (int_i) begin
        res_o.code = EXC_INT;
      end else if (exc_i[EF_ADEL_IF]) begin
        res_o.code    = EXC_ADEL;
        res_o.bad_sel = BAD_PC;
      end else if (exc_i[EF_RI]) begin
        res_o.code = EXC_RI;
      end else if (exc_i[EF_OV]) begin
        res_o.code = EXC_OV;
      end else if (exc_i[EF_TR]) begin
        res_o.code = TRAP_CODE;
      end else if (exc_i[EF_SYS]) begin
        res_o.code = EXC_SYS;
      end else if (exc_i[EF_BP]) begin
        res_o.code = EXC_BP;
      end else if (exc_i[EF_ADEL_LD]) begin
        res_o.code    = EXC_ADEL;
        res_o.bad_sel = BAD_DATA;
      end else if (exc_i[EF_ADES]) begin
        res_o.code    = EXC_ADES;
        res_o.bad_sel = BAD_DATA;
      end else if (eret_i) begin
        res_o.code = EXC_ERET;
      end
    end
  end

endmodule

// File: rtl/exc_commit.sv
// exc_commit -- exception commit unit at the MEM/CP0 boundary.
// Arbitrates MEM-stage exception flags against pending interrupts, hands the
// result (code, PC, delay-slot flag, bad address) to CP0, flushes IF..MEM and
// then holds the redirect target in a valid/ready handshake with fetch.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_*                     MEM-stage instruction state and exception flags
//   cp0_status/cause/epc      live CP0 registers
//   wb_cp0_we/waddr/data      WB-stage mtc0, forwarded so same-cycle writes count
//   excepttype_o              exception code to CP0 (0 = none)
//   current_inst_addr_o       MEM PC to CP0
//   is_in_delayslot_o         MEM delay-slot flag to CP0
//   bad_addr_o                BadVAddr for AdEL/AdES, else 0
//   flush_o                   kill IF..MEM
//   stall_o                   freeze IF..MEM while the redirect is pending
//   redirect_valid_o/ready_i  handshake carrying new_pc_o to fetch
//   new_pc_o                  redirect target, stable while valid
// Macro EXC_TRAP_EN (see exc_prio) selects a distinct trap code.
import exc_pkg::*;

module exc_commit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [7:0]  mem_exc,
  input  logic        mem_eret,
  input  logic [31:0] mem_data_addr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        wb_cp0_we,
  input  logic [4:0]  wb_cp0_waddr,
  input  logic [31:0] wb_cp0_data,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  input  logic        redirect_ready_i,
  output logic [31:0] new_pc_o
);

  // ---------------------------------------------------------------------
  // CP0 forwarding: an mtc0 in WB has not reached the register file yet,
  // so the MEM decision must see the value being written this cycle.
  // ---------------------------------------------------------------------
  logic [31:0] status_eff, cause_eff, epc_eff;

  always_comb begin
    status_eff = cp0_status;
    cause_eff  = cp0_cause;
    epc_eff    = cp0_epc;
    if (wb_cp0_we) begin
      case (wb_cp0_waddr)
        CP0_STATUS: status_eff = wb_cp0_data;
        CP0_CAUSE:  cause_eff  = cause_merge(cp0_cause, wb_cp0_data);
        CP0_EPC:    epc_eff    = wb_cp0_data;
        default:    ;
      endcase
    end
  end

  // IE set, not already at exception level, and some enabled line pending.
  logic int_pend;
  assign int_pend = (|(cause_eff[15:8] & status_eff[15:8])) &
                    status_eff[0] & ~status_eff[1];

  logic unused_cp0;
  assign unused_cp0 = ^{status_eff[31:16], status_eff[7:2],
                        cause_eff[31:16], cause_eff[7:0]};

  // ---------------------------------------------------------------------
  // Priority encoder
  // ---------------------------------------------------------------------
  prio_res_t prio;

  exc_prio u_prio (
    .valid_i (mem_valid),
    .int_i   (int_pend),
    .exc_i   (mem_exc),
    .eret_i  (mem_eret),
    .res_o   (prio)
  );

  logic exc_hit;
  assign exc_hit = (prio.code != EXC_NONE);

  assign current_inst_addr_o = mem_pc;
  assign is_in_delayslot_o   = mem_in_delayslot;

  // ---------------------------------------------------------------------
  // Redirect FSM
  // ---------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      new_pc_q <= EXC_VECTOR;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Next state and redirect target. The target is captured on the same
  // edge CP0 latches the exception and frozen until fetch takes it.
  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_hit) begin
          state_d  = ST_REDIR;
          new_pc_d = (prio.code == EXC_ERET) ? epc_eff : EXC_VECTOR;
        end
      end
      ST_REDIR: begin
        if (redirect_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. In REDIR the MEM instruction is the frozen victim of the
  // flush already taken, so nothing new may be reported to CP0.
  always_comb begin
    excepttype_o     = EXC_NONE;
    flush_o          = 1'b0;
    bad_addr_o       = 32'h0;
    stall_o          = 1'b0;
    redirect_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        excepttype_o = prio.code;
        flush_o      = exc_hit;
        case (prio.bad_sel)
          BAD_PC:   bad_addr_o = mem_pc;
          BAD_DATA: bad_addr_o = mem_data_addr;
          default:  bad_addr_o = 32'h0;
        endcase
      end
      ST_REDIR: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign new_pc_o = new_pc_q;

endmodule

// File: tb/tb_exc_commit.sv
module tb_exc_commit;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef EXC_TRAP_EN
  localparam logic [31:0] TRAP_EXP = 32'hd;
`else
  localparam logic [31:0] TRAP_EXP = 32'ha;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delayslot;
  logic [7:0]  mem_exc;
  logic        mem_eret;
  logic [31:0] mem_data_addr;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        wb_cp0_we;
  logic [4:0]  wb_cp0_waddr;
  logic [31:0] wb_cp0_data;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o, stall_o, redirect_valid_o;
  logic        redirect_ready_i;

  always #5 clk = ~clk;

  exc_commit dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_valid           (mem_valid),
    .mem_pc              (mem_pc),
    .mem_in_delayslot    (mem_in_delayslot),
    .mem_exc             (mem_exc),
    .mem_eret            (mem_eret),
    .mem_data_addr       (mem_data_addr),
    .cp0_status          (cp0_status),
    .cp0_cause           (cp0_cause),
    .cp0_epc             (cp0_epc),
    .wb_cp0_we           (wb_cp0_we),
    .wb_cp0_waddr        (wb_cp0_waddr),
    .wb_cp0_data         (wb_cp0_data),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .bad_addr_o          (bad_addr_o),
    .flush_o             (flush_o),
    .stall_o             (stall_o),
    .redirect_valid_o    (redirect_valid_o),
    .redirect_ready_i    (redirect_ready_i),
    .new_pc_o            (new_pc_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        mv;
    logic [31:0] pc;
    logic        ds;
    logic [7:0]  exc;
    logic        eret;
    logic [31:0] daddr, status, cause, epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] code, bad, npc;
  } vec_t;

  function automatic vec_t mk(input string name, input logic mv, input logic [31:0] pc,
                              input logic ds, input logic [7:0] exc, input logic eret,
                              input logic [31:0] daddr, input logic [31:0] status,
                              input logic [31:0] cause, input logic [31:0] epc,
                              input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic [31:0] code, input logic [31:0] bad,
                              input logic [31:0] npc);
    vec_t v;
    v.name = name; v.mv = mv; v.pc = pc; v.ds = ds; v.exc = exc; v.eret = eret;
    v.daddr = daddr; v.status = status; v.cause = cause; v.epc = epc;
    v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.code = code; v.bad = bad; v.npc = npc;
    return v;
  endfunction

  task automatic clear_inputs();
    mem_valid = 0; mem_pc = 32'h0; mem_in_delayslot = 0; mem_exc = 8'h0;
    mem_eret = 0; mem_data_addr = 32'h0; cp0_status = 32'h0; cp0_cause = 32'h0;
    cp0_epc = 32'h0; wb_cp0_we = 0; wb_cp0_waddr = 5'd0; wb_cp0_data = 32'h0;
  endtask

  task automatic apply(input vec_t v);
    mem_valid = v.mv; mem_pc = v.pc; mem_in_delayslot = v.ds; mem_exc = v.exc;
    mem_eret = v.eret; mem_data_addr = v.daddr; cp0_status = v.status;
    cp0_cause = v.cause; cp0_epc = v.epc; wb_cp0_we = v.we;
    wb_cp0_waddr = v.waddr; wb_cp0_data = v.wdata;
  endtask

  // advance one clock, land 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // name, mv, pc, ds, exc, eret, daddr, status, cause, epc, we, waddr, wdata, code, bad, npc
    vecs.push_back(mk("bubble",      0, 32'h8000_0000, 0, 8'hff, 1, 32'h10, 32'h401, 32'h400, 32'h0,    0, 5'd0,  32'h0,    32'h0, 32'h0, VEC));
    vecs.push_back(mk("int",         1, 32'h8000_0100, 0, 8'h00, 0, 32'h0,  32'h401, 32'h400, 32'h0,    0, 5'd0,  32'h0,    32'h1, 32'h0, VEC));
    vecs.push_back(mk("int_over_ad", 1, 32'h8000_0104, 1, 8'h81, 0, 32'h44, 32'h401, 32'h400, 32'h0,    0, 5'd0,  32'h0,    32'h1, 32'h0, VEC));
    vecs.push_back(mk("ades",        1, 32'h8000_0200, 0, 8'h80, 0, 32'h8000_0002, 32'h0, 32'h0, 32'h0, 0, 5'd0,  32'h0,    32'h5, 32'h8000_0002, VEC));
    vecs.push_back(mk("adel_if",     1, 32'h8000_0201, 1, 8'h81, 0, 32'h8000_0002, 32'h0, 32'h0, 32'h0, 0, 5'd0,  32'h0,    32'h4, 32'h8000_0201, VEC));
    vecs.push_back(mk("ri",          1, 32'h8000_0300, 0, 8'h02, 0, 32'h55, 32'h0,   32'h0,   32'h0,    0, 5'd0,  32'h0,    32'ha, 32'h0, VEC));
    vecs.push_back(mk("ov",          1, 32'h8000_0304, 0, 8'h04, 0, 32'h55, 32'h0,   32'h0,   32'h0,    0, 5'd0,  32'h0,    32'hc, 32'h0, VEC));
    vecs.push_back(mk("trap",        1, 32'h8000_0308, 0, 8'h08, 0, 32'h55, 32'h0,   32'h0,   32'h0,    0, 5'd0,  32'h0,    TRAP_EXP, 32'h0, VEC));
    vecs.push_back(mk("sys",         1, 32'h8000_030c, 0, 8'h10, 0, 32'h55, 32'h0,   32'h0,   32'h0,    0, 5'd0,  32'h0,    32'h8, 32'h0, VEC));
    vecs.push_back(mk("bp",          1, 32'h8000_0310, 0, 8'h20, 0, 32'h55, 32'h0,   32'h0,   32'h0,    0, 5'd0,  32'h0,    32'h9, 32'h0, VEC));
    vecs.push_back(mk("adel_ld",     1, 32'h8000_0314, 0, 8'h40, 0, 32'h1233, 32'h0, 32'h0,   32'h0,    0, 5'd0,  32'h0,    32'h4, 32'h1233, VEC));
    vecs.push_back(mk("sys_over_bp", 1, 32'h8000_0318, 0, 8'h30, 0, 32'h55, 32'h0,   32'h0,   32'h0,    0, 5'd0,  32'h0,    32'h8, 32'h0, VEC));
    vecs.push_back(mk("ld_over_st",  1, 32'h8000_031c, 0, 8'hc0, 0, 32'h77, 32'h0,   32'h0,   32'h0,    0, 5'd0,  32'h0,    32'h4, 32'h77, VEC));
    vecs.push_back(mk("ov_over_tr",  1, 32'h8000_0320, 0, 8'h0c, 0, 32'h55, 32'h0,   32'h0,   32'h0,    0, 5'd0,  32'h0,    32'hc, 32'h0, VEC));
    vecs.push_back(mk("eret_fwd",    1, 32'h8000_0400, 0, 8'h00, 1, 32'h0,  32'h0,   32'h0,   32'h1000, 1, 5'd14, 32'h2000, 32'he, 32'h0, 32'h2000));
    vecs.push_back(mk("eret_live",   1, 32'h8000_0404, 0, 8'h00, 1, 32'h0,  32'h0,   32'h0,   32'h1000, 0, 5'd14, 32'h2000, 32'he, 32'h0, 32'h1000));
    vecs.push_back(mk("sys_over_er", 1, 32'h8000_0408, 0, 8'h10, 1, 32'h0,  32'h0,   32'h0,   32'h1000, 0, 5'd0,  32'h0,    32'h8, 32'h0, VEC));
    vecs.push_back(mk("status_mask", 1, 32'h8000_0500, 0, 8'h00, 0, 32'h0,  32'h401, 32'h400, 32'h0,    1, 5'd12, 32'h0,    32'h0, 32'h0, VEC));
    vecs.push_back(mk("exl_blocks",  1, 32'h8000_0504, 0, 8'h00, 0, 32'h0,  32'h403, 32'h400, 32'h0,    0, 5'd0,  32'h0,    32'h0, 32'h0, VEC));
    vecs.push_back(mk("ie_off",      1, 32'h8000_0508, 0, 8'h00, 0, 32'h0,  32'h400, 32'h400, 32'h0,    0, 5'd0,  32'h0,    32'h0, 32'h0, VEC));
    vecs.push_back(mk("we_off",      1, 32'h8000_050c, 0, 8'h00, 0, 32'h0,  32'h401, 32'h400, 32'h0,    0, 5'd12, 32'h0,    32'h1, 32'h0, VEC));
    vecs.push_back(mk("sw_int_fwd",  1, 32'h8000_0510, 0, 8'h00, 0, 32'h0,  32'h101, 32'h0,   32'h0,    1, 5'd13, 32'h100,  32'h1, 32'h0, VEC));
    vecs.push_back(mk("cause_hwkeep",1, 32'h8000_0514, 0, 8'h00, 0, 32'h0,  32'h401, 32'h400, 32'h0,    1, 5'd13, 32'h0,    32'h1, 32'h0, VEC));
    vecs.push_back(mk("status_unmask",1,32'h8000_0518, 0, 8'h00, 0, 32'h0,  32'h0,   32'h400, 32'h0,    1, 5'd12, 32'h401,  32'h1, 32'h0, VEC));

    // ---- reset state ----
    clear_inputs();
    redirect_ready_i = 1;
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    chk("rst_valid",  {31'b0, redirect_valid_o}, 32'h0);
    chk("rst_stall",  {31'b0, stall_o},          32'h0);
    chk("rst_flush",  {31'b0, flush_o},          32'h0);
    chk("rst_code",   excepttype_o,              32'h0);
    chk("rst_newpc",  new_pc_o,                  VEC);

    // ---- table: combinational decision, then registered redirect ----
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      chk({vecs[i].name, "_code"},  excepttype_o, vecs[i].code);
      chk({vecs[i].name, "_flush"}, {31'b0, flush_o}, {31'b0, vecs[i].code != 0});
      chk({vecs[i].name, "_bad"},   bad_addr_o, vecs[i].bad);
      chk({vecs[i].name, "_pc"},    current_inst_addr_o, vecs[i].pc);
      chk({vecs[i].name, "_ds"},    {31'b0, is_in_delayslot_o}, {31'b0, vecs[i].ds});
      step();
      clear_inputs();
      #1;
      chk({vecs[i].name, "_rvalid"}, {31'b0, redirect_valid_o}, {31'b0, vecs[i].code != 0});
      chk({vecs[i].name, "_stall"},  {31'b0, stall_o}, {31'b0, vecs[i].code != 0});
      if (vecs[i].code != 0) chk({vecs[i].name, "_newpc"}, new_pc_o, vecs[i].npc);
      step();
      chk({vecs[i].name, "_back_idle"}, {31'b0, redirect_valid_o}, 32'h0);
    end

    // ---- handshake hold: fetch stalls 3 cycles, interrupt stays asserted ----
    redirect_ready_i = 0;
    apply(vecs[1]);
    #1;
    chk("hold_code0", excepttype_o, 32'h1);
    step();
    for (int c = 0; c < 3; c++) begin
      chk("hold_valid", {31'b0, redirect_valid_o}, 32'h1);
      chk("hold_stall", {31'b0, stall_o}, 32'h1);
      chk("hold_newpc", new_pc_o, VEC);
      chk("hold_code",  excepttype_o, 32'h0);
      chk("hold_flush", {31'b0, flush_o}, 32'h0);
      chk("hold_bad",   bad_addr_o, 32'h0);
      step();
    end
    redirect_ready_i = 1;
    clear_inputs();
    #1;
    chk("accept_valid", {31'b0, redirect_valid_o}, 32'h1);
    step();
    chk("accept_idle_valid", {31'b0, redirect_valid_o}, 32'h0);
    chk("accept_idle_stall", {31'b0, stall_o}, 32'h0);

    // ---- eret target then reset while REDIR ----
    redirect_ready_i = 0;
    mem_valid = 1; mem_pc = 32'h8000_0600; mem_eret = 1; cp0_epc = 32'h3000;
    #1;
    chk("rstmid_code", excepttype_o, 32'he);
    step();
    clear_inputs();
    #1;
    chk("rstmid_pre_valid", {31'b0, redirect_valid_o}, 32'h1);
    chk("rstmid_pre_newpc", new_pc_o, 32'h3000);
    rst = 1;
    step();
    rst = 0;
    chk("rstmid_valid", {31'b0, redirect_valid_o}, 32'h0);
    chk("rstmid_stall", {31'b0, stall_o}, 32'h0);
    chk("rstmid_newpc", new_pc_o, VEC);
    step();
    chk("rstmid_stays_idle", {31'b0, redirect_valid_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
